alu_issue_ctrl: RTL and testbench

//  Issue/writeback controller that drives the 8-bit ALU (sel/op1/op2 in, out/co back).

---
 rtl/alu_issue_ctrl.sv | 156 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issue/writeback controller for the 8-bit combinational ALU. It accepts
//   instruction words over a valid/ready stream and reads operands from a 4x8
//   register file. It issues one ALU operation, captures alu_out/alu_co, and
//   writes the result back to rd.
//
//   Instruction word: {op[7:5], rd[4:3], rs[2:1], imm[0]}. When imm=1, the next
//   accepted word is an immediate byte that replaces R[rs] as operand 2.
//
//   Optional feature: define ALU_ZERO_FLAG_EN to add the zero_flag output.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   instr_valid    instruction/immediate word valid
//   instr_data     instruction word or immediate byte
//   instr_ready    controller accepts a word this cycle (IDLE or IMM)
//   alu_sel        ALU operation select (op field)
//   alu_op1        R[rd]
//   alu_op2        R[rs] or immediate byte
//   alu_out        ALU result (combinational)
//   alu_co         ALU carry/shift-out
//   wb_valid       one-cycle pulse when a write-back is performed
//   wb_addr        register written
//   wb_data        value written
//   carry_flag     sticky carry, updated by add/ashl/div2 only
//   zero_flag      (ALU_ZERO_FLAG_EN only) result==0 on the last EXEC
//   busy           controller not in IDLE
//
// state | meaning
// IDLE  | waiting for an instruction word
// IMM   | instruction latched, waiting for its immediate byte
// EXEC  | ALU operands stable, result written at end of cycle

module alu_issue_ctrl #(
    parameter int                DATA_W   = 8,
    parameter int                NUM_REGS = 4,
    parameter logic [DATA_W-1:0] REG_INIT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [7:0]        instr_data,
    output logic              instr_ready,
    output logic [2:0]        alu_sel,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_co,
    output logic              wb_valid,
    output logic [1:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              carry_flag,
`ifdef ALU_ZERO_FLAG_EN
    output logic              zero_flag,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IMM  = 2'd1,
        EXEC = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [1:0]        rd_q;
    logic              accept;

    assign accept = instr_valid & instr_ready;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (instr_valid) begin
                    state_next = instr_data[0] ? IMM : EXEC;
                end
            end
            IMM: begin
                if (instr_valid) begin
                    state_next = EXEC;
                end
            end
            EXEC:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        instr_ready = (state == IDLE) || (state == IMM);
        busy        = (state != IDLE);
    end

    // operand latch, register file write-back and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= REG_INIT;
            end
            alu_sel    <= '0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            rd_q       <= '0;
            wb_valid   <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            carry_flag <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
            zero_flag  <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;

            if (accept && (state == IDLE)) begin
                alu_sel <= instr_data[7:5];
                alu_op1 <= regs[instr_data[4:3]];
                alu_op2 <= regs[instr_data[2:1]];
                rd_q    <= instr_data[4:3];
            end

            if (accept && (state == IMM)) begin
                alu_op2 <= instr_data[DATA_W-1:0];
            end

            // The write lands before the next IDLE accept reads the file,
            // so back-to-back dependent instructions need no bypass.
            if (state == EXEC) begin
                regs[rd_q] <= alu_out;
                wb_valid   <= 1'b1;
                wb_addr    <= rd_q;
                wb_data    <= alu_out;
                // only add, ashl and div2 produce a meaningful carry
                if ((alu_sel == 3'b000) || (alu_sel == 3'b001) || (alu_sel == 3'b011)) begin
                    carry_flag <= alu_co;
                end
`ifdef ALU_ZERO_FLAG_EN
                zero_flag <= (alu_out == '0);
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    logic       clk;
    logic       rst;
    logic       instr_valid;
    logic [7:0] instr_data;
    logic       instr_ready;
    logic [2:0] alu_sel;
    logic [7:0] alu_op1;
    logic [7:0] alu_op2;
    logic [7:0] alu_out;
    logic       alu_co;
    logic       wb_valid;
    logic [1:0] wb_addr;
    logic [7:0] wb_data;
    logic       carry_flag;
    logic       busy;
`ifdef ALU_ZERO_FLAG_EN
    logic       zero_flag;
`endif

    int checks;
    int failures;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_ready (instr_ready),
        .alu_sel     (alu_sel),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_out     (alu_out),
        .alu_co      (alu_co),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .carry_flag  (carry_flag),
`ifdef ALU_ZERO_FLAG_EN
        .zero_flag   (zero_flag),
`endif
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU the controller drives.
    // 000 add, 001 ashl, 010 and, 011 div2, 100 pass op2, 101 xnor, 110 or, 111 xor
    logic [8:0] sum;
    always_comb begin
        sum     = {1'b0, alu_op1} + {1'b0, alu_op2};
        alu_out = 8'h00;
        alu_co  = 1'b0;
        case (alu_sel)
            3'b000: begin alu_out = sum[7:0]; alu_co = sum[8]; end
            3'b001: begin alu_out = {alu_op1[6:0], 1'b0}; alu_co = alu_op1[7]; end
            3'b010: alu_out = alu_op1 & alu_op2;
            3'b011: begin alu_out = {1'b0, alu_op1[7:1]}; alu_co = alu_op1[0]; end
            3'b100: alu_out = alu_op2;
            3'b101: alu_out = ~(alu_op1 ^ alu_op2);
            3'b110: alu_out = alu_op1 | alu_op2;
            default: alu_out = alu_op1 ^ alu_op2;
        endcase
    end

    // Present one word and hold it until accepted; returns #1 after the accepting edge.
    task automatic send(input logic [7:0] w);
        int k;
        instr_valid = 1'b1;
        instr_data  = w;
        k = 0;
        while (!instr_ready && k < 8) begin
            @(posedge clk); #1;
            k++;
        end
        if (!instr_ready) begin
            checks++; failures++;
            $display("FAIL send_timeout word=%h instr_ready=%b required 1", w, instr_ready);
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr_data  = 8'h00;
    endtask

    // Non-immediate instruction; returns in the write-back cycle.
    task automatic do_instr(input logic [7:0] w);
        send(w);
        @(posedge clk); #1;
    endtask

    // R[rd] <= val via pass-op2 with immediate; returns in the write-back cycle.
    task automatic load_reg(input logic [1:0] rd, input logic [7:0] val);
        send({3'b100, rd, 2'b00, 1'b1});
        send(val);
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; instr_valid = 1'b0; instr_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", instr_ready); end
        checks++; if ({alu_sel, alu_op1, alu_op2} !== 19'h0) begin failures++; $display("FAIL rst_alu got=%h/%h/%h exp=0", alu_sel, alu_op1, alu_op2); end
        checks++; if ({wb_valid, wb_addr, wb_data, carry_flag} !== 12'h0) begin failures++; $display("FAIL rst_wb got=%b/%h/%h/%b exp=0", wb_valid, wb_addr, wb_data, carry_flag); end
`ifdef ALU_ZERO_FLAG_EN
        checks++; if (zero_flag !== 1'b0) begin failures++; $display("FAIL rst_zero got=%b exp=0", zero_flag); end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_imm;
        send(8'h81);
        checks++; if (busy !== 1'b1 || instr_ready !== 1'b1) begin failures++; $display("FAIL imm_state busy=%b ready=%b exp=1/1", busy, instr_ready); end
        send(8'h7F);
        checks++; if (alu_sel !== 3'b100 || alu_op2 !== 8'h7F) begin failures++; $display("FAIL imm_exec sel=%b op2=%h exp=100/7f", alu_sel, alu_op2); end
        checks++; if (instr_ready !== 1'b0 || wb_valid !== 1'b0) begin failures++; $display("FAIL imm_exec_hs ready=%b wb_valid=%b exp=0/0", instr_ready, wb_valid); end
        @(posedge clk); #1;
        checks++; if (wb_valid !== 1'b1 || wb_addr !== 2'd0 || wb_data !== 8'h7F) begin failures++; $display("FAIL imm_wb got=%b/%h/%h exp=1/0/7f", wb_valid, wb_addr, wb_data); end
        @(posedge clk); #1;
        checks++; if (wb_valid !== 1'b0 || wb_data !== 8'h7F) begin failures++; $display("FAIL imm_wb_hold got=%b/%h exp=0/7f", wb_valid, wb_data); end
    endtask

    task automatic test_reset_mid_imm;
        load_reg(2'd1, 8'h01);
        send(8'h91);                       // load R2, now waiting for immediate
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || instr_ready !== 1'b1) begin failures++; $display("FAIL midrst_state busy=%b ready=%b exp=0/1", busy, instr_ready); end
        checks++; if ({alu_sel, alu_op1, alu_op2, wb_valid, wb_addr, wb_data, carry_flag} !== 31'h0) begin failures++; $display("FAIL midrst_outs sel=%b op1=%h op2=%h wb=%b/%h/%h c=%b exp=0", alu_sel, alu_op1, alu_op2, wb_valid, wb_addr, wb_data, carry_flag); end
        rst = 1'b0;
        // must be decoded as add R0,R1 (registers back at zero), not as an immediate
        send(8'h02);
        checks++; if (busy !== 1'b1 || alu_sel !== 3'b000 || alu_op2 !== 8'h00) begin failures++; $display("FAIL midrst_discard busy=%b sel=%b op2=%h exp=1/000/00", busy, alu_sel, alu_op2); end
        @(posedge clk); #1;
        checks++; if (wb_valid !== 1'b1 || wb_addr !== 2'd0 || wb_data !== 8'h00) begin failures++; $display("FAIL midrst_wb got=%b/%h/%h exp=1/0/00", wb_valid, wb_addr, wb_data); end
    endtask

    task automatic test_add_carry;
        load_reg(2'd0, 8'hFF);
        load_reg(2'd1, 8'h01);
        send(8'h02);                       // add R0 = FF + 01
        checks++; if (alu_op1 !== 8'hFF || alu_op2 !== 8'h01) begin failures++; $display("FAIL add_ops got=%h/%h exp=ff/01", alu_op1, alu_op2); end
        @(posedge clk); #1;
        checks++; if (wb_valid !== 1'b1 || wb_addr !== 2'd0 || wb_data !== 8'h00 || carry_flag !== 1'b1) begin failures++; $display("FAIL add_wb got=%b/%h/%h c=%b exp=1/0/00 c=1", wb_valid, wb_addr, wb_data, carry_flag); end
        do_instr(8'hB8);                   // xnor R3 = ~(00 ^ 00)
        checks++; if (wb_addr !== 2'd3 || wb_data !== 8'hFF || carry_flag !== 1'b1) begin failures++; $display("FAIL xnor_hold got=%h/%h c=%b exp=3/ff c=1", wb_addr, wb_data, carry_flag); end
    endtask

    task automatic test_back_to_back;
        // R0=00, R1=01, R2=00. add R0=R0+R1, then add R2=R2+R0 with valid held.
        instr_valid = 1'b1; instr_data = 8'h02;
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL b2b_c0_ready got=%b exp=1", instr_ready); end
        @(posedge clk); #1;
        checks++; if (instr_ready !== 1'b0) begin failures++; $display("FAIL b2b_c1_ready got=%b exp=0", instr_ready); end
        instr_data = 8'h10;
        @(posedge clk); #1;
        checks++; if (instr_ready !== 1'b1 || wb_valid !== 1'b1 || wb_data !== 8'h01 || carry_flag !== 1'b0) begin failures++; $display("FAIL b2b_c2 ready=%b wb=%b/%h c=%b exp=1/1/01 c=0", instr_ready, wb_valid, wb_data, carry_flag); end
        @(posedge clk); #1;
        instr_valid = 1'b0; instr_data = 8'h00;
        checks++; if (instr_ready !== 1'b0 || wb_valid !== 1'b0 || alu_op2 !== 8'h01) begin failures++; $display("FAIL b2b_c3 ready=%b wb=%b op2=%h exp=0/0/01", instr_ready, wb_valid, alu_op2); end
        @(posedge clk); #1;
        checks++; if (wb_valid !== 1'b1 || wb_addr !== 2'd2 || wb_data !== 8'h01) begin failures++; $display("FAIL b2b_c4 wb=%b/%h/%h exp=1/2/01", wb_valid, wb_addr, wb_data); end
    endtask

    task automatic test_shift_div;
        load_reg(2'd2, 8'h81);
        do_instr(8'h34);                   // ashl R2
        checks++; if (wb_addr !== 2'd2 || wb_data !== 8'h02 || carry_flag !== 1'b1) begin failures++; $display("FAIL ashl got=%h/%h c=%b exp=2/02 c=1", wb_addr, wb_data, carry_flag); end
`ifdef ALU_ZERO_FLAG_EN
        checks++; if (zero_flag !== 1'b0) begin failures++; $display("FAIL ashl_zero got=%b exp=0", zero_flag); end
`endif
        do_instr(8'h00);                   // add R0 = 01 + 01, clears carry
        checks++; if (wb_data !== 8'h02 || carry_flag !== 1'b0) begin failures++; $display("FAIL add_clr got=%h c=%b exp=02 c=0", wb_data, carry_flag); end
        load_reg(2'd1, 8'h03);
        do_instr(8'h6A);                   // div2 R1
        checks++; if (wb_addr !== 2'd1 || wb_data !== 8'h01 || carry_flag !== 1'b1) begin failures++; $display("FAIL div2 got=%h/%h c=%b exp=1/01 c=1", wb_addr, wb_data, carry_flag); end
    endtask

    task automatic test_zero_flag;
        load_reg(2'd3, 8'hFF);
        load_reg(2'd0, 8'h00);
        do_instr(8'hB8);                   // xnor R3 = ~(FF ^ 00) = 00
        checks++; if (wb_valid !== 1'b1 || wb_addr !== 2'd3 || wb_data !== 8'h00) begin failures++; $display("FAIL xnor_zero_wb got=%b/%h/%h exp=1/3/00", wb_valid, wb_addr, wb_data); end
`ifdef ALU_ZERO_FLAG_EN
        checks++; if (zero_flag !== 1'b1) begin failures++; $display("FAIL zero_flag got=%b exp=1", zero_flag); end
`endif
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        instr_valid = 1'b0;
        instr_data = 8'h00;
        test_reset();
        test_load_imm();
        test_reset_mid_imm();
        test_add_carry();
        test_back_to_back();
        test_shift_div();
        test_zero_flag();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
